// File: rtl/hub75_scan_datapath_if.sv
// rtl/hub75_scan_datapath_if.sv - framebuffer read bus and panel pixel/row lines of the HUB75 scan datapath
//
// Purpose: bundles the RAM read port and the panel-side outputs of the scan datapath.
// Signals:
//   o_mem_addr   {row, col} framebuffer read address
//   o_mem_rd     read strobe for o_mem_addr
//   i_mem_data   RAM read data, one cycle after o_mem_rd ([5:3] upper rgb, [2:0] lower rgb)
//   o_data_r/g/b {upper, lower} colour bits towards the panel
//   o_pix_valid  o_data_* carry a new pixel this cycle
//   o_row_addr   panel row select
//   o_frame_done one-cycle pulse on row wrap
// Modports: master = datapath side, slave = RAM/panel side.
interface hub75_scan_datapath_if #(
  parameter int ROW_W = 4,
  parameter int COL_W = 6
);
  logic [ROW_W+COL_W-1:0] o_mem_addr;
  logic                   o_mem_rd;
  logic [5:0]             i_mem_data;
  logic [1:0]             o_data_r;
  logic [1:0]             o_data_g;
  logic [1:0]             o_data_b;
  logic                   o_pix_valid;
  logic [ROW_W-1:0]       o_row_addr;
  logic                   o_frame_done;

  modport master (
    output o_mem_addr, o_mem_rd,
    input  i_mem_data,
    output o_data_r, o_data_g, o_data_b, o_pix_valid,
    output o_row_addr, o_frame_done
  );

  modport slave (
    input  o_mem_addr, o_mem_rd,
    output i_mem_data,
    input  o_data_r, o_data_g, o_data_b, o_pix_valid,
    input  o_row_addr, o_frame_done
  );
endinterface

// File: rtl/hub75_scan_datapath.sv
// rtl/hub75_scan_datapath.sv - HUB75 scan datapath: column fetch, pixel pipeline and row address
//
// Purpose: turns the display FSM's column/row strobes into framebuffer reads, pipelines the
// returned pixel into the dual-half RGB lines and drives the panel row select.
// Ports:
//   i_clk, i_rst_n  clock (rising edge) and asynchronous active-low reset
//   addColumns      fetch next column while high (level)
//   rstColumns      clear column counter, wins over addColumns
//   addRow          advance row on its rising edge
//   compColumns     all COLS pixels fetched and the pipeline has drained
//   bus             read bus and panel outputs (hub75_scan_datapath_if.master)
module hub75_scan_datapath #(
  parameter int COLS  = 64,
  parameter int COL_W = 6,
  parameter int ROWS  = 16,
  parameter int ROW_W = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic addColumns,
  input  logic rstColumns,
  input  logic addRow,
  output logic compColumns,
  hub75_scan_datapath_if.master bus
);

  localparam logic [COL_W:0]   LP_COLS    = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0] LP_ROW_MAX = ROW_W'(ROWS-1);

  // Column counter is one bit wider than the address so it can saturate at COLS.
  logic [COL_W:0]   r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_rd_pend;
  logic             r_addrow_d;
  logic [1:0]       r_data_r;
  logic [1:0]       r_data_g;
  logic [1:0]       r_data_b;
  logic             r_pix_valid;
  logic             r_frame_done;

  logic w_col_avail;
  logic w_mem_rd;
  logic w_row_step;

  assign w_col_avail = (r_col < LP_COLS);
  assign w_mem_rd    = addColumns & ~rstColumns & w_col_avail;
  assign w_row_step  = addRow & ~r_addrow_d;

  // Row is sampled before its increment, so a fetch coinciding with an addRow edge
  // still reads the old row.
  assign bus.o_mem_addr   = {r_row, r_col[COL_W-1:0]};
  assign bus.o_mem_rd     = w_mem_rd;
  assign bus.o_data_r     = r_data_r;
  assign bus.o_data_g     = r_data_g;
  assign bus.o_data_b     = r_data_b;
  assign bus.o_pix_valid  = r_pix_valid;
  assign bus.o_row_addr   = r_row;
  assign bus.o_frame_done = r_frame_done;

  // Held low until reads in flight have left the pipeline, so the FSM never blanks
  // before the last pixel has been shifted out.
  assign compColumns = (r_col == LP_COLS) & ~r_rd_pend & ~r_pix_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
    end else if (rstColumns) begin
      r_col <= '0;
    end else if (addColumns && w_col_avail) begin
      r_col <= r_col + 1'b1;
    end
  end

  // rstColumns does not cancel a read already issued; it only stops new ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend   <= 1'b0;
      r_pix_valid <= 1'b0;
      r_data_r    <= '0;
      r_data_g    <= '0;
      r_data_b    <= '0;
    end else begin
      r_rd_pend   <= w_mem_rd;
      r_pix_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_data_r <= {bus.i_mem_data[5], bus.i_mem_data[2]};
        r_data_g <= {bus.i_mem_data[4], bus.i_mem_data[1]};
        r_data_b <= {bus.i_mem_data[3], bus.i_mem_data[0]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addrow_d   <= 1'b0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_addrow_d   <= addRow;
      r_frame_done <= w_row_step && (r_row == LP_ROW_MAX);
      if (w_row_step) begin
        r_row <= (r_row == LP_ROW_MAX) ? '0 : r_row + 1'b1;
      end
    end
  end

endmodule
